// File: rtl/reg_bus_master_pkg.sv
// rtl/reg_bus_master_pkg.sv - shared register-bus constants, frame opcodes and state types
// REG_BUS_MASTER_WRITE_ACK_EN adds the ACK serializer state.
package reg_bus_master_pkg;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 4;
  localparam int IDX_W     = $clog2(FRAME_LEN);

  localparam logic [7:0] OP_WRITE    = 8'h01;
  localparam logic [7:0] OP_READ     = 8'h02;
  localparam logic [7:0] WR_ACK_BYTE = 8'hAC;

  typedef enum logic [1:0] {ST_RX, ST_WR, ST_RD_WAIT, ST_RSP} state_t;

  typedef enum logic [1:0] {
    SER_IDLE, SER_LO, SER_HI
`ifdef REG_BUS_MASTER_WRITE_ACK_EN
    , SER_ACK
`endif
  } ser_state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/reg_bus_master_if.sv
// rtl/reg_bus_master_if.sv - host byte streams plus register bus seen by the bus master
interface reg_bus_master_if;
  import reg_bus_master_pkg::*;

  logic [7:0]        cmd_data_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [7:0]        rsp_data_o;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic              reg_we_o;
  logic [ADDR_W-1:0] reg_addr_o;
  logic [DATA_W-1:0] reg_data_o;
  logic [DATA_W-1:0] reg_data_i;

  modport master (
    input  cmd_data_i, cmd_valid_i, rsp_ready_i, reg_data_i,
    output cmd_ready_o, rsp_data_o, rsp_valid_o, reg_we_o, reg_addr_o, reg_data_o
  );

  modport slave (
    output cmd_data_i, cmd_valid_i, rsp_ready_i, reg_data_i,
    input  cmd_ready_o, rsp_data_o, rsp_valid_o, reg_we_o, reg_addr_o, reg_data_o
  );
endinterface

// File: rtl/reg_bus_rsp_ser.sv
// rtl/reg_bus_rsp_ser.sv - 16-bit read data to two response bytes, low byte first
// REG_BUS_MASTER_WRITE_ACK_EN adds a single-byte write acknowledge.
module reg_bus_rsp_ser
  import reg_bus_master_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
`ifdef REG_BUS_MASTER_WRITE_ACK_EN
  input  logic              ack_i,
`endif
  output logic [7:0]        rsp_data_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              last_o
);
  ser_state_t state;
  logic [7:0] hi_q;

`ifdef REG_BUS_MASTER_WRITE_ACK_EN
  assign last_o = rsp_valid_o && rsp_ready_i && (state == SER_HI || state == SER_ACK);
`else
  assign last_o = rsp_valid_o && rsp_ready_i && (state == SER_HI);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= SER_IDLE;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= 8'h00;
      hi_q        <= 8'h00;
    end else begin
      case (state)
        SER_IDLE: begin
          if (load_i) begin
            rsp_data_o  <= data_i[7:0];
            hi_q        <= data_i[15:8];
            rsp_valid_o <= 1'b1;
            state       <= SER_LO;
          end
`ifdef REG_BUS_MASTER_WRITE_ACK_EN
          if (ack_i) begin
            rsp_data_o  <= WR_ACK_BYTE;
            rsp_valid_o <= 1'b1;
            state       <= SER_ACK;
          end
`endif
        end
        SER_LO: if (rsp_ready_i) begin
          rsp_data_o <= hi_q;
          state      <= SER_HI;
        end
        SER_HI: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          state       <= SER_IDLE;
        end
`ifdef REG_BUS_MASTER_WRITE_ACK_EN
        SER_ACK: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          state       <= SER_IDLE;
        end
`endif
        default: state <= SER_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - parses 4-byte host frames and runs them on the register bus
// REG_BUS_MASTER_WRITE_ACK_EN makes every write answer with one 0xAC byte.
module reg_bus_master
  import reg_bus_master_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 65535
) (
  input  logic             clk_i,
  input  logic             rst_i,
  reg_bus_master_if.master bus,
  output logic             busy_o,
  output logic [7:0]       err_cnt_o
);
  localparam logic [3:0]       LAT_LAST = 4'(READ_LATENCY - 1);
  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       op_q, addr_q, lo_q;
  logic [15:0]      tmo_cnt;
  logic [3:0]       lat_cnt;
  logic             acc, ser_load, ser_last;

  assign acc      = bus.cmd_valid_i && bus.cmd_ready_o;
  assign ser_load = (state == ST_RD_WAIT) && (lat_cnt == LAT_LAST);

`ifdef REG_BUS_MASTER_WRITE_ACK_EN
  logic ser_ack;
  assign ser_ack = (state == ST_WR);
`endif

  reg_bus_rsp_ser u_ser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (ser_load),
    .data_i      (bus.reg_data_i),
`ifdef REG_BUS_MASTER_WRITE_ACK_EN
    .ack_i       (ser_ack),
`endif
    .rsp_data_o  (bus.rsp_data_o),
    .rsp_valid_o (bus.rsp_valid_o),
    .rsp_ready_i (bus.rsp_ready_i),
    .last_o      (ser_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_RX;
      idx             <= '0;
      op_q            <= 8'h00;
      addr_q          <= 8'h00;
      lo_q            <= 8'h00;
      tmo_cnt         <= 16'h0000;
      lat_cnt         <= 4'h0;
      bus.cmd_ready_o <= 1'b0;
      bus.reg_we_o    <= 1'b0;
      bus.reg_addr_o  <= '0;
      bus.reg_data_o  <= '0;
      busy_o          <= 1'b0;
      err_cnt_o       <= 8'h00;
    end else begin
      case (state)
        ST_RX: begin
          bus.cmd_ready_o <= 1'b1;
          if (acc) begin
            tmo_cnt <= 16'h0000;
            if (idx == IDX_LAST) begin
              idx <= '0;
              if (op_q == OP_WRITE) begin
                bus.reg_addr_o  <= addr_q;
                bus.reg_data_o  <= {bus.cmd_data_i, lo_q};
                bus.reg_we_o    <= 1'b1;
                bus.cmd_ready_o <= 1'b0;
                busy_o          <= 1'b1;
                state           <= ST_WR;
              end else if (op_q == OP_READ) begin
                bus.reg_addr_o  <= addr_q;
                lat_cnt         <= 4'h0;
                bus.cmd_ready_o <= 1'b0;
                busy_o          <= 1'b1;
                state           <= ST_RD_WAIT;
              end else begin
                err_cnt_o <= sat_inc(err_cnt_o);
              end
            end else begin
              idx <= idx + 1'b1;
              if (idx == '0)              op_q   <= bus.cmd_data_i;
              else if (idx == IDX_W'(1))  addr_q <= bus.cmd_data_i;
              else                        lo_q   <= bus.cmd_data_i;
            end
          end else if (idx != '0) begin
            // A stalled partial frame is thrown away once the host goes quiet too long.
            if (tmo_cnt == TMO_LAST) begin
              tmo_cnt   <= 16'h0000;
              idx       <= '0;
              err_cnt_o <= sat_inc(err_cnt_o);
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
        end
        ST_WR: begin
          bus.reg_we_o <= 1'b0;
`ifdef REG_BUS_MASTER_WRITE_ACK_EN
          state <= ST_RSP;
`else
          state           <= ST_RX;
          busy_o          <= 1'b0;
          bus.cmd_ready_o <= 1'b1;
`endif
        end
        ST_RD_WAIT: begin
          if (lat_cnt == LAT_LAST) state   <= ST_RSP;
          else                     lat_cnt <= lat_cnt + 4'd1;
        end
        ST_RSP: begin
          if (ser_last) begin
            state           <= ST_RX;
            busy_o          <= 1'b0;
            bus.cmd_ready_o <= 1'b1;
          end
        end
        default: state <= ST_RX;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_bus_master.sv
// tb/tb_reg_bus_master.sv - directed frames against two masters (read latency 1 and 3)
// REG_BUS_MASTER_WRITE_ACK_EN switches the expected write response to one 0xAC byte.
module tb_reg_bus_master;
  import reg_bus_master_pkg::*;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       rsp_ready = 1'b1;

  reg_bus_master_if ifa ();
  reg_bus_master_if ifb ();
  logic       busy_a, busy_b;
  logic [7:0] err_a, err_b;

  reg_bus_master #(.READ_LATENCY(1), .TIMEOUT(TMO)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa.master), .busy_o(busy_a), .err_cnt_o(err_a));
  reg_bus_master #(.READ_LATENCY(3), .TIMEOUT(TMO)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb.master), .busy_o(busy_b), .err_cnt_o(err_b));

  always #5 clk = ~clk;

  assign ifa.cmd_data_i  = cmd_data;
  assign ifa.cmd_valid_i = cmd_valid && !sel;
  assign ifa.rsp_ready_i = rsp_ready && !sel;
  assign ifb.cmd_data_i  = cmd_data;
  assign ifb.cmd_valid_i = cmd_valid && sel;
  assign ifb.rsp_ready_i = rsp_ready && sel;

  function automatic logic [15:0] slave_mem(input logic [7:0] a);
    return (a == 8'h18) ? 16'h5678 : {a, ~a};
  endfunction

  // Slave B answers from the address seen two cycles earlier (latency 3 including the address cycle).
  logic [7:0] b_d1 = 8'h00, b_d2 = 8'h00;
  always @(posedge clk) begin
    b_d1 <= ifb.reg_addr_o;
    b_d2 <= b_d1;
  end
  assign ifa.reg_data_i = slave_mem(ifa.reg_addr_o);
  assign ifb.reg_data_i = slave_mem(b_d2);

  logic        obs_ready, obs_rsp_valid, obs_we, obs_busy;
  logic [7:0]  obs_rsp_data, obs_addr, obs_err;
  logic [15:0] obs_wdata;
  assign obs_ready     = sel ? ifb.cmd_ready_o : ifa.cmd_ready_o;
  assign obs_rsp_valid = sel ? ifb.rsp_valid_o : ifa.rsp_valid_o;
  assign obs_rsp_data  = sel ? ifb.rsp_data_o  : ifa.rsp_data_o;
  assign obs_we        = sel ? ifb.reg_we_o    : ifa.reg_we_o;
  assign obs_addr      = sel ? ifb.reg_addr_o  : ifa.reg_addr_o;
  assign obs_wdata     = sel ? ifb.reg_data_o  : ifa.reg_data_o;
  assign obs_busy      = sel ? busy_b : busy_a;
  assign obs_err       = sel ? err_b  : err_a;

  int         we_cnt = 0;
  logic [7:0] rsp_q[$];
  always @(negedge clk) begin
    if (obs_we) we_cnt++;
    if (obs_rsp_valid && rsp_ready && !rst) rsp_q.push_back(obs_rsp_data);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!obs_ready && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) check("cmd_ready_wait", 32'(n), 0);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!obs_rsp_valid && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  task automatic check_read(input string tag, input int q0);
    check({tag, "_n"},  32'(rsp_q.size() - q0), 2);
    check({tag, "_lo"}, 32'(rsp_q[q0]), 'h78);
    check({tag, "_hi"}, 32'(rsp_q[q0 + 1]), 'h56);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, we0, q0;
    tick(1);
    check("rst_cmd_ready", 32'(obs_ready), 0);
    check("rst_rsp_valid", 32'(obs_rsp_valid), 0);
    check("rst_rsp_data",  32'(obs_rsp_data), 0);
    check("rst_we",        32'(obs_we), 0);
    check("rst_addr",      32'(obs_addr), 0);
    check("rst_wdata",     32'(obs_wdata), 0);
    check("rst_busy",      32'(obs_busy), 0);
    check("rst_err",       32'(obs_err), 0);
    rst = 1'b0;
    tick(1);

    // write 01 18 34 12
    we0 = we_cnt; q0 = rsp_q.size();
    send_frame(8'h01, 8'h18, 8'h34, 8'h12);
    check("wr_we",    32'(obs_we), 1);
    check("wr_addr",  32'(obs_addr), 'h18);
    check("wr_data",  32'(obs_wdata), 'h1234);
    check("wr_busy",  32'(obs_busy), 1);
    check("wr_ready", 32'(obs_ready), 0);
    tick(1);
    check("wr_we_off", 32'(obs_we), 0);
    tick(4);
    check("wr_we_cnt", 32'(we_cnt - we0), 1);
`ifdef REG_BUS_MASTER_WRITE_ACK_EN
    check("wr_ack_n", 32'(rsp_q.size() - q0), 1);
    check("wr_ack",   32'(rsp_q[q0]), 'hAC);
`else
    check("wr_rsp_n", 32'(rsp_q.size() - q0), 0);
`endif
    check("wr_err", 32'(obs_err), 0);

    // read, latency 1
    we0 = we_cnt; q0 = rsp_q.size();
    send_frame(8'h02, 8'h18, 8'h00, 8'h00);
    wait_rsp(n);
    check("rd1_lat", 32'(n), 1);
    tick(4);
    check_read("rd1", q0);
    check("rd1_we", 32'(we_cnt - we0), 0);

    // read, latency 3
    sel = 1'b1;
    we0 = we_cnt; q0 = rsp_q.size();
    send_frame(8'h02, 8'h18, 8'h00, 8'h00);
    wait_rsp(n);
    check("rd3_lat", 32'(n), 3);
    tick(5);
    check_read("rd3", q0);
    check("rd3_we", 32'(we_cnt - we0), 0);
    sel = 1'b0;

    // response stalled by the host
    rsp_ready = 1'b0;
    q0 = rsp_q.size();
    send_frame(8'h02, 8'h18, 8'h00, 8'h00);
    wait_rsp(n);
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 32'(obs_rsp_valid), 1);
      check("stall_data",  32'(obs_rsp_data), 'h78);
      check("stall_ready", 32'(obs_ready), 0);
      tick(1);
    end
    rsp_ready = 1'b1;
    tick(4);
    check_read("stall", q0);

    // bad opcode then a valid write
    we0 = we_cnt;
    send_frame(8'h07, 8'h10, 8'hAA, 8'hBB);
    tick(1);
    check("bad_err",  32'(obs_err), 1);
    check("bad_we",   32'(we_cnt - we0), 0);
    check("bad_busy", 32'(obs_busy), 0);
    send_frame(8'h01, 8'h10, 8'h01, 8'h00);
    tick(3);
    check("bad_wr_we",   32'(we_cnt - we0), 1);
    check("bad_wr_addr", 32'(obs_addr), 'h10);
    check("bad_wr_data", 32'(obs_wdata), 'h0001);
    for (int i = 0; i < 300; i++) send_frame(8'h07, i[7:0], 8'h00, 8'h00);
    tick(1);
    check("err_sat", 32'(obs_err), 'hFF);

    // inter-byte timeout
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    check("tmo_err0", 32'(obs_err), 0);
    we0 = we_cnt;
    send_byte(8'h01);
    send_byte(8'h20);
    tick(TMO);
    send_frame(8'h01, 8'h20, 8'hEF, 8'hBE);
    tick(3);
    check("tmo_err",  32'(obs_err), 1);
    check("tmo_we",   32'(we_cnt - we0), 1);
    check("tmo_addr", 32'(obs_addr), 'h20);
    check("tmo_data", 32'(obs_wdata), 'hBEEF);
    // byte accepted on the expiry cycle keeps the frame alive
    send_byte(8'h01);
    send_byte(8'h20);
    tick(TMO - 1);
    send_byte(8'hFE);
    send_byte(8'hCA);
    tick(3);
    check("tmo_edge_err",  32'(obs_err), 1);
    check("tmo_edge_we",   32'(we_cnt - we0), 2);
    check("tmo_edge_data", 32'(obs_wdata), 'hCAFE);

    // reset while the high response byte is pending
    rsp_ready = 1'b0;
    send_frame(8'h02, 8'h18, 8'h00, 8'h00);
    wait_rsp(n);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    check("txhi_valid", 32'(obs_rsp_valid), 1);
    check("txhi_data",  32'(obs_rsp_data), 'h56);
    rst = 1'b1;
    tick(1);
    check("rst_tx_valid", 32'(obs_rsp_valid), 0);
    check("rst_tx_busy",  32'(obs_busy), 0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick(1);
    q0 = rsp_q.size();
    send_frame(8'h02, 8'h18, 8'h00, 8'h00);
    wait_rsp(n);
    tick(4);
    check_read("post_rst", q0);

    // reset on the same edge as B3 of a write: no strobe
    we0 = we_cnt;
    send_byte(8'h01);
    send_byte(8'h30);
    send_byte(8'h55);
    cmd_data  = 8'h66;
    cmd_valid = 1'b1;
    rst       = 1'b1;
    tick(1);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    tick(3);
    check("rst_wr_we", 32'(we_cnt - we0), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
